// File: rtl/aes_pkg.sv
// Shared AES definitions: forward S-box, GF(2^8) helpers, block constants and the
// round-key slice macro. The inverse-cipher path imports the same package.
`ifndef AES_PKG_SV
`define AES_PKG_SV

// Round key i of a flat expanded-key bus holding nr+1 keys, key 0 in the MSBs.
`define AES_RK(bus, i, nr) bus[aes_pkg::BLK*((nr)+1)-1-aes_pkg::BLK*(i) -: aes_pkg::BLK]

package aes_pkg;

    localparam int BLK = 128;

    typedef enum logic {IDLE, RUN} fsm_e;

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] gmul2(input logic [7:0] b);
        return xtime(b);
    endfunction

    function automatic logic [7:0] gmul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

endpackage

`endif

// File: rtl/cipher_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows, MixColumns (skipped
// when last=1), AddRoundKey. Byte i of the state sits at bits [127-8i -: 8].
module cipher_round
    import aes_pkg::*;
(
    input  logic [BLK-1:0] state_in,
    input  logic [BLK-1:0] rk,
    input  logic           last,
    output logic [BLK-1:0] state_out
);

    logic [7:0]     sr [16];
    logic [7:0]     mc [16];
    logic [BLK-1:0] pre_key;

    // Byte (row r, col c) takes the substituted byte from column (c+r)%4 of the same row.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c+r] = sbox(state_in[BLK-1-8*(4*((c+r)%4)+r) -: 8]);
            end
        end
    end

    always_comb begin
        for (int c = 0; c < 4; c++) begin
            mc[4*c+0] = gmul2(sr[4*c+0]) ^ gmul3(sr[4*c+1]) ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+1] = sr[4*c+0] ^ gmul2(sr[4*c+1]) ^ gmul3(sr[4*c+2]) ^ sr[4*c+3];
            mc[4*c+2] = sr[4*c+0] ^ sr[4*c+1] ^ gmul2(sr[4*c+2]) ^ gmul3(sr[4*c+3]);
            mc[4*c+3] = gmul3(sr[4*c+0]) ^ sr[4*c+1] ^ sr[4*c+2] ^ gmul2(sr[4*c+3]);
        end
        pre_key = '0;
        for (int i = 0; i < 16; i++) begin
            pre_key[BLK-1-8*i -: 8] = last ? sr[i] : mc[i];
        end
    end

    assign state_out = pre_key ^ rk;

endmodule

// File: rtl/cipher_iter.sv
// Iterative AES-128/192/256 encryptor: one round per clock over a registered state,
// round keys picked from the caller's flat expanded-key bus (must stay stable mid-block).
module cipher_iter
    import aes_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BLK-1:0]        in_data,
    input  logic [BLK*(Nr+1)-1:0] w,
    output logic                  busy,
    output logic                  done,
    output logic [BLK-1:0]        out_data
);

    localparam logic [3:0] LAST_RND = 4'(Nr);

    if (!((Nk == 4 || Nk == 6 || Nk == 8) && Nr == Nk + 6)) begin : g_bad_cfg
        $error("cipher_iter: unsupported Nk/Nr combination");
    end

    fsm_e           fsm_q, fsm_d;
    logic [3:0]     round_q, round_d;
    logic [BLK-1:0] state_q, state_d;
    logic [BLK-1:0] out_data_q, out_data_d;
    logic           done_q, done_d;

    logic [BLK-1:0] rk_arr [Nr+1];
    logic [BLK-1:0] rk, rnd_out;
    logic [3:0]     rk_idx;

    for (genvar i = 0; i <= Nr; i++) begin : g_rk
        assign rk_arr[i] = `AES_RK(w, i, Nr);
    end

    // In IDLE the mux serves key 0 for the initial whitening on the start edge.
    assign rk_idx = (fsm_q == RUN) ? round_q : 4'd0;
    assign rk     = (rk_idx <= LAST_RND) ? rk_arr[rk_idx] : '0;

    cipher_round u_round (
        .state_in  (state_q),
        .rk        (rk),
        .last      (round_q == LAST_RND),
        .state_out (rnd_out)
    );

    always_comb begin
        fsm_d      = fsm_q;
        round_d    = round_q;
        state_d    = state_q;
        out_data_d = out_data_q;
        done_d     = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (start) begin
                    state_d = in_data ^ rk;
                    round_d = 4'd1;
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                if (round_q == LAST_RND) begin
                    out_data_d = rnd_out;
                    done_d     = 1'b1;
                    round_d    = 4'd0;
                    fsm_d      = IDLE;
                end else if (round_q != 4'd0 && round_q < LAST_RND) begin
                    state_d = rnd_out;
                    round_d = round_q + 4'd1;
                end else begin
                    // Count values outside 1..Nr cannot occur in normal flow; recover.
                    round_d = 4'd0;
                    fsm_d   = IDLE;
                end
            end
            default: begin
                round_d = 4'd0;
                fsm_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q      <= IDLE;
            round_q    <= 4'd0;
            state_q    <= '0;
            out_data_q <= '0;
            done_q     <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            round_q    <= round_d;
            state_q    <= state_d;
            out_data_q <= out_data_d;
            done_q     <= done_d;
        end
    end

    assign busy     = (fsm_q == RUN);
    assign done     = done_q;
    assign out_data = out_data_q;

endmodule
